key_matrix_scanner: RTL and testbench

Parametrised keyboard-matrix scanner that time-shares the LCD data/select bus with the `lcd` driver. It periodically pauses the LCD, turns the shared data pins into pulled-up inputs, walks an active-low column strobe, samples the rows, and debounces the whole matrix. Press and release changes go into an event FIFO with a valid/ready output toward the UART or host logic. It replaces the fixed 9-column ad-hoc scan loop in `top` and sits between the LCD driver, the `SB_IO` row buffers and the column pins.

---
 rtl/key_matrix_scanner_if.sv | 26 ++
 rtl/key_matrix_scanner.sv | 180 ++++++++++++++++++
 tb/tb_key_matrix_scanner.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_matrix_scanner_if.sv
// Shared LCD bus, matrix pins and event stream of the key matrix scanner.
// master = scanner, slave = the LCD driver / pins / consumer side.
interface key_matrix_scanner_if #(
    parameter int ROWS = 8,
    parameter int COLS = 9
);
    logic            lcd_pause;
    logic            lcd_idle;
    logic            bus_output_enable;
    logic [COLS-1:0] col_drive;
    logic [ROWS-1:0] row_in;
    logic            event_valid;
    logic            event_ready;
    logic [7:0]      event_data;
    logic            overflow;

    modport master (
        output lcd_pause, bus_output_enable, col_drive, event_valid, event_data, overflow,
        input  lcd_idle, row_in, event_ready
    );

    modport slave (
        input  lcd_pause, bus_output_enable, col_drive, event_valid, event_data, overflow,
        output lcd_idle, row_in, event_ready
    );
endinterface

// File: rtl/key_matrix_scanner.sv
// Keyboard matrix scanner time-sharing the LCD bus: periodic column walk, whole-matrix
// debounce, and press/release events queued in a FIFO toward the host.
module key_matrix_scanner #(
    parameter int ROWS       = 8,
    parameter int COLS       = 9,
    parameter int INTERVAL   = 524288,
    parameter int SETTLE     = 500,
    parameter int SAMPLE     = 500,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    key_matrix_scanner_if.master bus
);
    localparam int KEYS  = ROWS * COLS;
    localparam int KEY_W = (KEYS > 1) ? $clog2(KEYS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W = $clog2(INTERVAL + SETTLE + SAMPLE + 1);
    localparam int AGR_W = $clog2(DEBOUNCE + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PAUSE, S_SETTLE, S_DRIVE, S_CAPTURE, S_RELEASE, S_COMPARE, S_WALK
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [COL_W-1:0]     col, col_nxt;
    logic [KEY_W-1:0]     key, key_nxt;
    logic [1:0][ROWS-1:0] row_sync;
    logic [KEYS-1:0]      raw, prev, stable;
    logic [AGR_W-1:0]     agree, agree_upd;
    logic                 push, push_ok, pop;
    logic [7:0]           push_data, head_nxt;
    logic [7:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_nxt;
    logic [FCT_W-1:0]     fcnt, fcnt_rem, fcnt_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Rows idle high through the pull-ups; the reset value keeps the matrix released.
    always_ff @(posedge clk or posedge reset)
        if (reset) row_sync <= '1;
        else       row_sync <= {row_sync[0], bus.row_in};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        col_nxt   = col;
        key_nxt   = key;
        case (state)
            S_IDLE:
                if (cnt == CNT_W'(INTERVAL - 1)) begin
                    state_nxt = S_PAUSE;
                    cnt_nxt   = '0;
                end else cnt_nxt = cnt + 1'b1;
            S_PAUSE:
                if (bus.lcd_idle) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = '0;
                    col_nxt   = '0;
                end
            S_SETTLE:
                if (cnt == CNT_W'(SETTLE - 1)) begin
                    state_nxt = S_DRIVE;
                    cnt_nxt   = '0;
                end else cnt_nxt = cnt + 1'b1;
            S_DRIVE:
                if (cnt == CNT_W'(SAMPLE - 1)) begin
                    state_nxt = S_CAPTURE;
                    cnt_nxt   = '0;
                end else cnt_nxt = cnt + 1'b1;
            S_CAPTURE:
                if (col == COL_W'(COLS - 1)) state_nxt = S_RELEASE;
                else begin
                    state_nxt = S_DRIVE;
                    col_nxt   = col + 1'b1;
                end
            S_RELEASE: state_nxt = S_COMPARE;
            S_COMPARE: begin
                cnt_nxt = '0;
                key_nxt = '0;
                state_nxt = (agree_upd == AGR_W'(DEBOUNCE - 1)) ? S_WALK : S_IDLE;
            end
            S_WALK:
                if (key == KEY_W'(KEYS - 1)) state_nxt = S_IDLE;
                else key_nxt = key + 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            col   <= '0;
            key   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            col   <= col_nxt;
            key   <= key_nxt;
        end

    // Outputs decode the next state so each one is a plain flop matching the state.
    // Columns float high during CAPTURE, giving the one-cycle gap between strobes.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bus.lcd_pause         <= 1'b0;
            bus.bus_output_enable <= 1'b1;
            bus.col_drive         <= '1;
        end else begin
            bus.lcd_pause         <= state_nxt inside {S_PAUSE, S_SETTLE, S_DRIVE, S_CAPTURE};
            bus.bus_output_enable <= !(state_nxt inside {S_SETTLE, S_DRIVE, S_CAPTURE});
            bus.col_drive         <= (state_nxt == S_DRIVE) ? ~(COLS'(1) << col_nxt) : '1;
        end

    always_comb begin
        agree_upd = '0;
        if (raw == prev)
            agree_upd = (agree == AGR_W'(DEBOUNCE - 1)) ? agree : agree + 1'b1;
    end

    assign push      = (state == S_WALK) && (raw[key] != stable[key]);
    assign push_data = {raw[key], 7'(key)};

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            raw    <= '0;
            prev   <= '0;
            stable <= '0;
            agree  <= '0;
        end else begin
            if (state == S_CAPTURE)
                for (int c = 0; c < COLS; c++)
                    if (col == COL_W'(c)) raw[c*ROWS +: ROWS] <= ~row_sync[1];
            if (state == S_COMPARE) begin
                prev  <= raw;
                agree <= agree_upd;
            end
            // Stable follows raw even when the FIFO drops the event.
            if (push) stable[key] <= raw[key];
        end

    assign pop     = bus.event_valid && bus.event_ready;
    assign push_ok = push && ((fcnt != FCT_W'(FIFO_DEPTH)) || pop);

    // The head register is reloaded from memory, or straight from the push when
    // the FIFO would otherwise be empty.
    always_comb begin
        rd_nxt   = pop ? ptr_inc(rd_ptr) : rd_ptr;
        fcnt_rem = fcnt - FCT_W'(pop);
        fcnt_nxt = fcnt_rem + FCT_W'(push_ok);
        head_nxt = (fcnt_rem == '0) ? push_data : mem[rd_nxt];
    end

    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= push_data;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fcnt            <= '0;
            bus.event_valid <= 1'b0;
            bus.event_data  <= '0;
            bus.overflow    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            rd_ptr          <= rd_nxt;
            fcnt            <= fcnt_nxt;
            bus.event_valid <= (fcnt_nxt != '0);
            if (fcnt_nxt != '0) bus.event_data <= head_nxt;
            if (push && !push_ok) bus.overflow <= 1'b1;
        end
endmodule

// File: tb/tb_key_matrix_scanner.sv
// Bench for key_matrix_scanner: a switch-matrix model on the pins and a scan-level
// reference model of debounce and event generation.
module tb_key_matrix_scanner;
  localparam int ROWS = 8, COLS = 9, INTERVAL = 64, SETTLE = 4, SAMPLE = 4;
  localparam int DEBOUNCE = 2, FIFO_DEPTH = 4;
  localparam int KEYS = ROWS * COLS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  key_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  key_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .INTERVAL(INTERVAL), .SETTLE(SETTLE), .SAMPLE(SAMPLE),
    .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int fails = 0;

  // Switch matrix: a pressed key shorts its row to its column strobe.
  logic [KEYS-1:0] pressed = '0;
  always_comb begin
    bus.row_in = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[c*ROWS + r] && !bus.col_drive[c]) bus.row_in[r] = 1'b0;
  end

  logic [7:0] got[$];
  always @(negedge clk)
    if (!reset && bus.event_valid && bus.event_ready) got.push_back(bus.event_data);

  logic [KEYS-1:0] m_prev = '0, m_stable = '0;
  int m_agree = 0;
  logic [7:0] exp_q[$];

  function void model_reset();
    m_prev = '0; m_stable = '0; m_agree = 0; exp_q.delete();
  endfunction

  function void model_scan(input logic [KEYS-1:0] m);
    if (m == m_prev) m_agree = (m_agree + 1 > DEBOUNCE - 1) ? DEBOUNCE - 1 : m_agree + 1;
    else m_agree = 0;
    m_prev = m;
    if (m_agree == DEBOUNCE - 1)
      for (int k = 0; k < KEYS; k++)
        if (m[k] != m_stable[k]) begin
          exp_q.push_back({m[k], 7'(k)});
          m_stable[k] = m[k];
        end
  endfunction

  // One complete scan with matrix m held; returns with the DUT idle again.
  task automatic run_scan(input logic [KEYS-1:0] m);
    int n;
    bit ok;
    pressed = m;
    bus.lcd_idle = 1'b1;
    ok = 1;
    n = 0;
    while (bus.lcd_pause !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    if (bus.lcd_pause !== 1'b1) ok = 0;
    n = 0;
    while (ok && bus.bus_output_enable !== 1'b0 && n < 50) begin @(posedge clk); #1; n++; end
    if (bus.bus_output_enable !== 1'b0) ok = 0;
    n = 0;
    while (ok && bus.bus_output_enable !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (bus.bus_output_enable !== 1'b1) ok = 0;
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL scan_timeout: lcd_pause=%b bus_output_enable=%b, scan did not complete",
               bus.lcd_pause, bus.bus_output_enable);
    end
    repeat (KEYS + 6) @(posedge clk);
    #1;
    model_scan(m);
  endtask

  task automatic test_reset();
    int n, bad;
    bus.lcd_idle = 1'b0;
    bus.event_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.lcd_pause, bus.bus_output_enable, bus.col_drive, bus.event_valid, bus.event_data, bus.overflow}
        !== {1'b0, 1'b1, 9'h1FF, 1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: pause=%b oe=%b col=%h valid=%b data=%h ovf=%b required 0 1 1ff 0 00 0",
               bus.lcd_pause, bus.bus_output_enable, bus.col_drive, bus.event_valid,
               bus.event_data, bus.overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (bus.lcd_pause !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== INTERVAL) begin
      fails++;
      $display("FAIL pause_latency: lcd_pause after %0d cycles, required %0d", n, INTERVAL);
    end
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (bus.bus_output_enable !== 1'b1 || bus.col_drive !== 9'h1FF || bus.lcd_pause !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL pause_hold: %0d cycles with bus taken or pause dropped, required 0", bad);
    end
  endtask

  task automatic test_column_walk();
    int n, cur_col, cur_len, dec, illegal, overlap, gaps;
    int run_col[$], run_len[$];
    bit first_oe;
    logic [COLS-1:0] pat;
    bus.lcd_idle = 1'b1;
    cur_col = -1; cur_len = 0; illegal = 0; overlap = 0; gaps = 0;
    n = 0;
    @(posedge clk); #1;
    first_oe = bus.bus_output_enable;
    while (bus.bus_output_enable !== 1'b1 && n < 200) begin
      dec = -1;
      if (bus.col_drive !== 9'h1FF) begin
        dec = -2;
        for (int c = 0; c < COLS; c++) begin
          pat = ~(COLS'(1) << c);
          if (bus.col_drive === pat) dec = c;
        end
      end else gaps++;
      if (dec == -2) illegal++;
      if (dec != cur_col) begin
        if (cur_col >= 0) begin run_col.push_back(cur_col); run_len.push_back(cur_len); end
        cur_col = dec; cur_len = 1;
      end else cur_len++;
      @(posedge clk); #1;
      n++;
      if (bus.bus_output_enable === 1'b1 && bus.col_drive !== 9'h1FF) overlap++;
    end
    if (cur_col >= 0) begin run_col.push_back(cur_col); run_len.push_back(cur_len); end
    checks++;
    if (first_oe !== 1'b0) begin
      fails++;
      $display("FAIL oe_fall: bus_output_enable=%b one cycle after lcd_idle, required 0", first_oe);
    end
    checks++;
    if (bus.bus_output_enable !== 1'b1 || bus.col_drive !== 9'h1FF || overlap != 0 || illegal != 0) begin
      fails++;
      $display("FAIL walk_release: oe=%b col=%h overlap=%0d illegal=%0d, required 1 1ff 0 0",
               bus.bus_output_enable, bus.col_drive, overlap, illegal);
    end
    checks++;
    if (gaps != SETTLE + COLS) begin
      fails++;
      $display("FAIL walk_gaps: %0d bus-released idle cycles, required %0d", gaps, SETTLE + COLS);
    end
    checks++;
    if (run_col.size() != COLS) begin
      fails++;
      $display("FAIL walk_columns: %0d column strobes, required %0d", run_col.size(), COLS);
    end else begin
      int bad_runs = 0;
      for (int i = 0; i < COLS; i++) if (run_col[i] != i || run_len[i] != SAMPLE) bad_runs++;
      checks++;
      if (bad_runs != 0) begin
        fails++;
        $display("FAIL walk_order: %0d strobes out of order or not %0d cycles long, required 0",
                 bad_runs, SAMPLE);
      end
    end
    repeat (KEYS + 6) @(posedge clk);
    #1;
    model_scan('0);
  endtask

  task automatic test_debounce();
    logic [KEYS-1:0] k19;
    k19 = '0;
    k19[2*ROWS + 3] = 1'b1;
    got.delete();
    run_scan(k19);
    checks++;
    if (got.size() != 0) begin
      fails++; $display("FAIL press_first_scan: %0d events, required 0", got.size());
    end
    run_scan(k19);
    checks++;
    if (got.size() != 1 || got[0] !== 8'h93) begin
      fails++; $display("FAIL press_event: count=%0d first=%h, required 1 93", got.size(), got[0]);
    end
    run_scan('0);
    checks++;
    if (got.size() != 1) begin
      fails++; $display("FAIL release_first_scan: %0d events, required 1", got.size());
    end
    run_scan('0);
    checks++;
    if (got.size() != 2 || got[1] !== 8'h13) begin
      fails++; $display("FAIL release_event: count=%0d second=%h, required 2 13", got.size(), got[1]);
    end
    run_scan(k19);
    run_scan('0);
    run_scan('0);
    checks++;
    if (got.size() != 2) begin
      fails++; $display("FAIL glitch: %0d events, required 2", got.size());
    end
  endtask

  task automatic test_random();
    logic [KEYS-1:0] m;
    int bad;
    m = '0;
    bus.event_ready = 1'b1;
    for (int s = 0; s < 8; s++) begin
      if (s == 0 || $urandom_range(0, 1) == 0)
        for (int k = 0; k < KEYS; k++) m[k] = ($urandom_range(0, 11) == 0);
      got.delete();
      exp_q.delete();
      run_scan(m);
      checks++;
      if (got.size() != exp_q.size()) begin
        fails++; $display("FAIL random_count: scan %0d got %0d events, required %0d", s, got.size(), exp_q.size());
      end else begin
        bad = 0;
        for (int i = 0; i < got.size(); i++) if (got[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin
          fails++; $display("FAIL random_data: scan %0d has %0d wrong events, required 0", s, bad);
        end
      end
    end
  endtask

  task automatic test_back_to_back_backpressure();
    logic [KEYS-1:0] m;
    logic [7:0] prev_data;
    bit prev_hold;
    int holds, hold_err, bad;
    bus.event_ready = 1'b1;
    run_scan('0);
    run_scan('0);
    m = '0;
    m[$urandom_range(0, 23)] = 1'b1;
    m[$urandom_range(24, 47)] = 1'b1;
    m[$urandom_range(48, 71)] = 1'b1;
    got.delete();
    exp_q.delete();
    bus.event_ready = 1'b0;
    run_scan(m);
    run_scan(m);
    checks++;
    if (got.size() != 0 || bus.event_valid !== 1'b1) begin
      fails++; $display("FAIL bp_pending: popped=%0d valid=%b, required 0 1", got.size(), bus.event_valid);
    end
    prev_hold = 0; prev_data = '0; holds = 0; hold_err = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.event_ready = (i % 2 == 1);
      @(negedge clk);
      if (prev_hold) begin
        holds++;
        if (bus.event_valid !== 1'b1 || bus.event_data !== prev_data) hold_err++;
      end
      prev_hold = bus.event_valid && !bus.event_ready;
      prev_data = bus.event_data;
    end
    bus.event_ready = 1'b1;
    checks++;
    if (holds == 0 || hold_err != 0) begin
      fails++; $display("FAIL bp_hold: %0d of %0d stalled cycles changed data, required 0 of >0", hold_err, holds);
    end
    checks++;
    if (got.size() != 3 || exp_q.size() != 3) begin
      fails++; $display("FAIL bp_count: got %0d events, required 3", got.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 3; i++) if (got[i] !== exp_q[i]) bad++;
      if (got[0][6:0] >= got[1][6:0] || got[1][6:0] >= got[2][6:0]) bad++;
      checks++;
      if (bad != 0) begin
        fails++; $display("FAIL bp_order: got %h %h %h, required %h %h %h",
                          got[0], got[1], got[2], exp_q[0], exp_q[1], exp_q[2]);
      end
    end
  endtask

  task automatic test_overflow();
    int bad;
    bus.event_ready = 1'b1;
    run_scan('0);
    run_scan('0);
    got.delete();
    exp_q.delete();
    bus.event_ready = 1'b0;
    run_scan(72'h3F);
    checks++;
    if (bus.overflow !== 1'b0) begin
      fails++; $display("FAIL ovf_early: overflow=%b after first scan, required 0", bus.overflow);
    end
    run_scan(72'h3F);
    checks++;
    if (bus.overflow !== 1'b1 || bus.event_valid !== 1'b1 || bus.event_data !== 8'h80) begin
      fails++; $display("FAIL ovf_set: overflow=%b valid=%b data=%h, required 1 1 80",
                        bus.overflow, bus.event_valid, bus.event_data);
    end
    bus.event_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < got.size() && i < 4; i++) if (got[i] !== 8'h80 + 8'(i)) bad++;
    checks++;
    if (got.size() != 4 || bad != 0) begin
      fails++; $display("FAIL ovf_drain: got %0d events with %0d wrong, required 4 (80..83) with 0", got.size(), bad);
    end
    got.delete();
    exp_q.delete();
    run_scan('0);
    run_scan('0);
    bad = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
    checks++;
    if (got.size() != 6 || exp_q.size() != 6 || bad != 0) begin
      fails++; $display("FAIL ovf_release: got %0d events with %0d wrong, required 6 (00..05)", got.size(), bad);
    end
    checks++;
    if (bus.overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_sticky: overflow=%b, required 1", bus.overflow);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [KEYS-1:0] x;
    int n;
    x = '0;
    x[40] = 1'b1;
    bus.event_ready = 1'b1;
    run_scan(x);
    got.delete();
    n = 0;
    while (bus.col_drive !== 9'h1EF && n < 400) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.col_drive !== 9'h1EF) begin
      fails++; $display("FAIL mid_wait: col_drive=%h, required 1ef", bus.col_drive);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.col_drive, bus.bus_output_enable, bus.lcd_pause, bus.event_valid, bus.overflow}
        !== {9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL mid_async: col=%h oe=%b pause=%b valid=%b ovf=%b, required 1ff 1 0 0 0",
               bus.col_drive, bus.bus_output_enable, bus.lcd_pause, bus.event_valid, bus.overflow);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    n = 0;
    while (bus.lcd_pause !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== INTERVAL) begin
      fails++; $display("FAIL mid_restart: lcd_pause after %0d cycles, required %0d", n, INTERVAL);
    end
    run_scan(x);
    checks++;
    if (got.size() != 0) begin
      fails++; $display("FAIL mid_stale: %0d events after reset scan, required 0", got.size());
    end
    run_scan(x);
    checks++;
    if (got.size() != 1 || got[0] !== 8'hA8) begin
      fails++; $display("FAIL mid_resume: count=%0d first=%h, required 1 a8", got.size(), got[0]);
    end
  endtask

  initial begin
    bus.lcd_idle = 1'b0;
    bus.event_ready = 1'b1;
    test_reset();
    test_column_walk();
    test_debounce();
    test_random();
    test_back_to_back_backpressure();
    test_overflow();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
